// File: rtl/seq_det_pkg.sv
// Shared types and helpers for the configurable serial pattern detector.
// Helpers work on a fixed 32-bit width so any module parameterisation can use them.
package seq_det_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam int unsigned FN_W = 32;

    // Low `len` bits set; lengths of FN_W or more give an all-ones mask.
    function automatic logic [FN_W-1:0] len_mask(input logic [FN_W-1:0] len);
        logic [FN_W-1:0] one;
        one = 1;
        if (len >= FN_W) begin
            return '1;
        end
        return (one << len) - one;
    endfunction

    function automatic logic [FN_W-1:0] sat_inc(input logic [FN_W-1:0] val,
                                                input logic [FN_W-1:0] max_val);
        if (val >= max_val) begin
            return max_val;
        end
        return val + 1;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with synchronous clear; sat is registered alongside count.
module sat_counter
    import seq_det_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count,
    output logic             sat
);

    logic [CNT_W-1:0] count_q, count_d;
    logic             sat_q;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc) begin
            count_d = CNT_W'(sat_inc(32'(count_q), 32'({CNT_W{1'b1}})));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
            sat_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            sat_q   <= (count_d == {CNT_W{1'b1}});
        end
    end

    assign count = count_q;
    assign sat   = sat_q;

endmodule

// File: rtl/seq_detector_cfg.sv
// Programmable serial pattern detector with Mealy match pulse, overlap control,
// input-valid qualification and a saturating match counter.
module seq_detector_cfg
    import seq_det_pkg::*;
#(
    parameter  int MAX_LEN = 8,
    parameter  int CNT_W   = 8,
    localparam int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic               x_valid,
    input  logic               x,
    output logic               y,
    output logic               armed,
    output logic               cfg_err,
    output logic [CNT_W-1:0]   match_count,
    output logic               count_sat
);

    state_e               state_q;
    logic [MAX_LEN-1:0]   pat_q;
    logic [LEN_W-1:0]     len_q;
    logic                 ovl_q;
    logic [MAX_LEN-2:0]   hist_q, hist_d;
    logic [LEN_W-1:0]     fill_q, fill_d;
    logic                 cfg_err_q;

    logic [MAX_LEN-1:0]   window;
    logic [FN_W-1:0]      mask_full, win_ext, pat_ext;
    logic                 fill_ok, shift, match, len_legal;

    // Window = stored history with the current bit appended as the newest (LSB).
    assign window    = {hist_q, x};
    assign mask_full = len_mask(32'(len_q));
    assign win_ext   = FN_W'(window);
    assign pat_ext   = FN_W'(pat_q);
    assign fill_ok   = ({1'b0, fill_q} + (LEN_W+1)'(1)) >= {1'b0, len_q};
    assign shift     = (state_q == RUN) && x_valid && !cfg_load;
    assign match     = shift && !reset && fill_ok
                       && ((win_ext & mask_full) == (pat_ext & mask_full));
    assign len_legal = (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));

    always_comb begin
        hist_d = window[MAX_LEN-2:0];
        fill_d = fill_q;
        if (match && !ovl_q) begin
            fill_d = '0;
        end else if (fill_q < len_q) begin
            fill_d = fill_q + LEN_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            pat_q     <= '0;
            len_q     <= '0;
            ovl_q     <= 1'b0;
            hist_q    <= '0;
            fill_q    <= '0;
            cfg_err_q <= 1'b0;
        end else if (cfg_load) begin
            pat_q     <= cfg_pattern;
            len_q     <= cfg_len;
            ovl_q     <= cfg_overlap;
            hist_q    <= '0;
            fill_q    <= '0;
            state_q   <= len_legal ? RUN : IDLE;
            cfg_err_q <= !len_legal;
        end else if (shift) begin
            hist_q <= hist_d;
            fill_q <= fill_d;
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_match_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (cfg_load),
        .inc   (match),
        .count (match_count),
        .sat   (count_sat)
    );

    assign y       = match;
    assign armed   = (state_q == RUN);
    assign cfg_err = cfg_err_q;

endmodule

// File: tb/tb_seq_detector_cfg.sv
// Bench for seq_detector_cfg: two instances (8-bit and 2-bit counters) share stimulus and
// are checked against a bit-list reference model through an expected-response queue.
module tb_seq_detector_cfg;

  localparam int MAX_LEN = 8;
  localparam int LEN_W   = 4;

  logic               clk = 1'b0;
  logic               reset, cfg_load, cfg_overlap, x_valid, x;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               y, armed, cfg_err, count_sat;
  logic [7:0]         match_count;
  logic               y_s, armed_s, cfg_err_s, count_sat_s;
  logic [1:0]         match_count_s;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic       y;
    logic       armed;
    logic       err;
    logic [7:0] cnt;
    logic       sat;
    logic [1:0] cnt_s;
    logic       sat_s;
  } exp_t;

  exp_t exp_q[$];

  // reference model state
  bit         m_run, m_err, m_ovl;
  logic [7:0] m_pat;
  int         m_len, m_cnt;
  int         m_bits[$];

  always #5 clk = ~clk;

  seq_detector_cfg #(.MAX_LEN(MAX_LEN), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .x_valid(x_valid), .x(x),
    .y(y), .armed(armed), .cfg_err(cfg_err), .match_count(match_count), .count_sat(count_sat)
  );

  seq_detector_cfg #(.MAX_LEN(MAX_LEN), .CNT_W(2)) dut_s (
    .clk(clk), .reset(reset), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .x_valid(x_valid), .x(x),
    .y(y_s), .armed(armed_s), .cfg_err(cfg_err_s), .match_count(match_count_s),
    .count_sat(count_sat_s)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // The last len bits of (history since clear, then x) must equal the pattern, MSB first.
  function automatic bit model_match(input bit xb);
    int n;
    int pos;
    bit b;
    n = m_bits.size();
    if (n + 1 < m_len) return 1'b0;
    for (int i = 0; i < m_len; i++) begin
      pos = n + 1 - m_len + i;
      b = (pos == n) ? xb : m_bits[pos][0];
      if (b != m_pat[m_len-1-i]) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic model_step(input logic r, input logic ld, input logic [7:0] p,
                            input logic [3:0] l, input logic o, input logic v, input logic xb);
    exp_t e;
    bit   hit;
    hit     = !r && m_run && v && !ld && model_match(xb);
    e.y     = hit;
    e.armed = m_run;
    e.err   = m_err;
    e.cnt   = (m_cnt > 255) ? 8'd255 : 8'(m_cnt);
    e.sat   = (m_cnt >= 255);
    e.cnt_s = (m_cnt > 3) ? 2'd3 : 2'(m_cnt);
    e.sat_s = (m_cnt >= 3);
    exp_q.push_back(e);
    if (r) begin
      m_run = 0; m_err = 0; m_ovl = 0; m_pat = '0; m_len = 0; m_cnt = 0;
      m_bits.delete();
    end else if (ld) begin
      m_pat = p; m_len = int'(l); m_ovl = o; m_cnt = 0;
      m_bits.delete();
      m_run = (m_len >= 1 && m_len <= MAX_LEN);
      m_err = !m_run;
    end else if (m_run && v) begin
      if (hit) m_cnt++;
      if (hit && !m_ovl) begin
        m_bits.delete();
      end else begin
        m_bits.push_back(int'(xb));
        while (m_bits.size() > MAX_LEN - 1) void'(m_bits.pop_front());
      end
    end
  endtask

  task automatic cyc(input logic r, input logic ld, input logic [7:0] p, input logic [3:0] l,
                     input logic o, input logic v, input logic xb);
    @(posedge clk);
    #1;
    reset = r; cfg_load = ld; cfg_pattern = p; cfg_len = l; cfg_overlap = o;
    x_valid = v; x = xb;
    model_step(r, ld, p, l, o, v, xb);
  endtask

  task automatic load(input logic [7:0] p, input logic [3:0] l, input logic o);
    cyc(1'b0, 1'b1, p, l, o, 1'b0, 1'b0);
  endtask

  task automatic bit_in(input logic xb);
    cyc(1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b1, xb);
  endtask

  task automatic gap();
    cyc(1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0);
  endtask

  // monitor: inputs for a cycle settle at posedge+1, so mid-cycle shows y and pre-edge state
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("y", 32'(y), 32'(e.y));
      check("y_s", 32'(y_s), 32'(e.y));
      check("armed", 32'(armed), 32'(e.armed));
      check("armed_s", 32'(armed_s), 32'(e.armed));
      check("cfg_err", 32'(cfg_err), 32'(e.err));
      check("cfg_err_s", 32'(cfg_err_s), 32'(e.err));
      check("match_count", 32'(match_count), 32'(e.cnt));
      check("count_sat", 32'(count_sat), 32'(e.sat));
      check("match_count_s", 32'(match_count_s), 32'(e.cnt_s));
      check("count_sat_s", 32'(count_sat_s), 32'(e.sat_s));
    end
  end

  initial begin
    logic [3:0] rl;
    int         wait_cnt;
    reset = 1'b1; cfg_load = 1'b0; cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0;
    x_valid = 1'b0; x = 1'b0;
    m_run = 0; m_err = 0; m_ovl = 0; m_pat = '0; m_len = 0; m_cnt = 0;
    repeat (2) @(posedge clk);
    gap();

    // 111 overlapping: hits on 4th and 5th bit
    load(8'b111, 4'd3, 1'b1);
    bit_in(0); bit_in(1); bit_in(1); bit_in(1); bit_in(1); bit_in(0);
    gap();
    @(negedge clk);
    check("t1_count", 32'(match_count), 32'd2);

    // 111 non-overlapping: hit on 4th, then again only after three fresh ones
    load(8'b111, 4'd3, 1'b0);
    bit_in(0); bit_in(1); bit_in(1); bit_in(1); bit_in(1); bit_in(1); bit_in(1);
    gap();
    @(negedge clk);
    check("t2_count", 32'(match_count), 32'd2);

    // 0110 with a two-cycle valid gap between bits 2 and 3
    load(8'b0110, 4'd4, 1'b1);
    bit_in(0); bit_in(1); gap(); gap(); bit_in(1); bit_in(0); bit_in(1); bit_in(1); bit_in(0);
    gap();
    @(negedge clk);
    check("t3_count", 32'(match_count), 32'd2);

    // illegal length 0, then 9 (beyond MAX_LEN)
    load(8'hff, 4'd0, 1'b1);
    bit_in(1); bit_in(1); bit_in(1); bit_in(1);
    gap();
    @(negedge clk);
    check("t4_err", 32'(cfg_err), 32'd1);
    check("t4_armed", 32'(armed), 32'd0);
    load(8'hff, 4'd9, 1'b1);
    bit_in(1); bit_in(1);

    // len 1 saturation: 2-bit counter pins at 3
    load(8'b1, 4'd1, 1'b0);
    repeat (5) bit_in(1);
    gap();
    @(negedge clk);
    check("t5_count_s", 32'(match_count_s), 32'd3);
    check("t5_sat_s", 32'(count_sat_s), 32'd1);

    // cfg_load racing x_valid, and full-length pattern
    load(8'b10110011, 4'd8, 1'b1);
    cyc(1'b0, 1'b1, 8'b1, 4'd1, 1'b1, 1'b1, 1'b1);
    bit_in(1);

    // reset mid-sequence, with x=1 on the reset cycle
    load(8'b111, 4'd3, 1'b1);
    bit_in(1); bit_in(1);
    cyc(1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 1'b1);
    bit_in(1);
    gap();
    @(negedge clk);
    check("t6_armed", 32'(armed), 32'd0);
    check("t6_count", 32'(match_count), 32'd0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 399) == 0) begin
        cyc(1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end else if ($urandom_range(0, 59) == 0 || i == 0) begin
        if ($urandom_range(0, 9) == 0) rl = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(9, 15));
        else rl = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 8)) : 4'($urandom_range(1, 4));
        cyc(1'b0, 1'b1, 8'($urandom_range(0, 255)), rl, 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end else begin
        cyc(1'b0, 1'b0, 8'h00, 4'd0, 1'b0, ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
      end
    end
    gap();

    wait_cnt = 0;
    while (exp_q.size() > 0 && wait_cnt < 10) begin
      @(posedge clk);
      wait_cnt++;
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
